// File: rtl/sift_sector_pkg.sv
// Shared types and sizing helpers for the SIFT sector controller.
// Holds the FSM state encoding and the beat-count constant functions.
package sift_sector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // 32-bit words needed to hold one IFP_LINE x IFP_LINE bit-plane
  function automatic int calc_wpr(input int ifp_line);
    return (ifp_line * ifp_line - 1) / 32 + 1;
  endfunction

  function automatic int calc_n_in(input int sector_line, input int data_size, input int wpr);
    return sector_line * sector_line * data_size * wpr;
  endfunction

  // The core returns ten fewer bit-planes per sector than it was loaded with
  function automatic int calc_n_out(input int sector_line, input int data_size, input int wpr);
    return sector_line * sector_line * (data_size - 10) * wpr;
  endfunction

  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/axi_sift_sector_ctrl_if.sv
// AXI-Stream style channel bundle used for the four streams of the controller.
interface axi_sift_sector_ctrl_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sift_beat_counter.sv
// Accepted-beat counter that wraps to zero after beat LIMIT-1.
// last flags the final beat of a transfer.
module sift_beat_counter
  import sift_sector_pkg::*;
#(
  parameter int LIMIT = 342
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        inc,
  output logic [cnt_width(LIMIT)-1:0] count,
  output logic                        last
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] count_q, count_d;

  assign last  = (count_q == CW'(LIMIT - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axi_sift_sector_ctrl.sv
// Sequences one SIFT sector job: load the core, wait for its run, drain results.
// Define SIFT_CTRL_TIMEOUT_EN to add a RUN-state watchdog (parameter TIMEOUT_CYCLES).
module axi_sift_sector_ctrl
   import sift_sector_pkg::*;
#(
   parameter int IFP_LINE      = 3,
   parameter int SECTOR_LINE   = 3,
   parameter int DATA_SIZE     = 38,
   parameter int SETTLE_CYCLES = 3
`ifdef SIFT_CTRL_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 65536
`endif
) (
   input  logic        axis_clk_i,
   input  logic        axis_rst_i,
   input  logic        start_i,
   input  logic        type_i,
   input  logic        abort_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        type_reg_o,
   input  logic        s_axis_tvalid_i,
   output logic        s_axis_tready_o,
   input  logic [31:0] s_axis_tdata_i,
   input  logic        s_axis_tlast_i,
   output logic        core_s_tvalid_o,
   input  logic        core_s_tready_i,
   output logic [31:0] core_s_tdata_o,
   output logic        core_s_tlast_o,
   input  logic        run_end_i,
   input  logic        core_m_tvalid_i,
   output logic        core_m_tready_o,
   input  logic [31:0] core_m_tdata_i,
   output logic        m_axis_tvalid_o,
   input  logic        m_axis_tready_i,
   output logic [31:0] m_axis_tdata_o,
   output logic        m_axis_tlast_o
);

   localparam int WPR   = calc_wpr(IFP_LINE);
   localparam int N_IN  = calc_n_in(SECTOR_LINE, DATA_SIZE, WPR);
   localparam int N_OUT = calc_n_out(SECTOR_LINE, DATA_SIZE, WPR);
   localparam int IN_W  = cnt_width(N_IN);
   localparam int OUT_W = cnt_width(N_OUT);
   localparam int SW    = cnt_width(SETTLE_CYCLES);

   state_e           stateQ, stateD;
   logic             typeQ, typeD;
   logic             errQ, errD;
   logic [SW-1:0]    settleQ, settleD;
   logic [IN_W-1:0]  inCount;
   logic [OUT_W-1:0] outCount;
   logic             inLast, outLast;
   logic             loadEn, drainEn, inFire, outFire, cntClr;
`ifdef SIFT_CTRL_TIMEOUT_EN
   logic [31:0]      wdogQ, wdogD;
`endif

   // Both streams are pure wires gated by state, so reset drops them instantly
   assign loadEn          = (stateQ == ST_LOAD);
   assign drainEn         = (stateQ == ST_DRAIN);
   assign core_s_tvalid_o = loadEn & s_axis_tvalid_i;
   assign core_s_tdata_o  = loadEn ? s_axis_tdata_i : '0;
   assign core_s_tlast_o  = loadEn & inLast;
   assign s_axis_tready_o = loadEn & core_s_tready_i;
   assign m_axis_tvalid_o = drainEn & core_m_tvalid_i;
   assign m_axis_tdata_o  = drainEn ? core_m_tdata_i : '0;
   assign m_axis_tlast_o  = drainEn & outLast;
   assign core_m_tready_o = drainEn & m_axis_tready_i;

   assign inFire  = core_s_tvalid_o & core_s_tready_i;
   assign outFire = m_axis_tvalid_o & m_axis_tready_i;
   assign cntClr  = abort_i | (stateQ == ST_IDLE);

   assign busy_o     = (stateQ != ST_IDLE);
   assign done_o     = (stateQ == ST_DONE);
   assign err_o      = errQ;
   assign type_reg_o = typeQ;

   sift_beat_counter #(.LIMIT(N_IN)) u_in_cnt (
      .clk   (axis_clk_i),
      .rst   (axis_rst_i),
      .clr   (cntClr),
      .inc   (inFire),
      .count (inCount),
      .last  (inLast)
   );

   sift_beat_counter #(.LIMIT(N_OUT)) u_out_cnt (
      .clk   (axis_clk_i),
      .rst   (axis_rst_i),
      .clr   (cntClr),
      .inc   (outFire),
      .count (outCount),
      .last  (outLast)
   );

   // Next-state logic: abort overrides everything, otherwise walk the job phases
   always_comb begin
      stateD  = stateQ;
      typeD   = typeQ;
      errD    = errQ;
      settleD = settleQ;
`ifdef SIFT_CTRL_TIMEOUT_EN
      wdogD   = wdogQ;
`endif
      if (abort_i) begin
         stateD = ST_IDLE;
      end else begin
         unique case (stateQ)
            ST_IDLE: begin
               if (start_i) begin
                  stateD = ST_LOAD;
                  typeD  = type_i;
                  errD   = 1'b0;
               end
            end
            ST_LOAD: begin
               if (inFire && s_axis_tlast_i && (inCount != IN_W'(N_IN - 1))) begin
                  errD = 1'b1;
               end
               if (inFire && inLast) begin
                  stateD = ST_RUN;
`ifdef SIFT_CTRL_TIMEOUT_EN
                  wdogD  = '0;
`endif
               end
            end
            ST_RUN: begin
               if (run_end_i) begin
                  stateD  = ST_SETTLE;
                  settleD = '0;
               end
`ifdef SIFT_CTRL_TIMEOUT_EN
               else if (wdogQ == 32'(TIMEOUT_CYCLES - 1)) begin
                  stateD = ST_IDLE;
                  errD   = 1'b1;
               end else begin
                  wdogD = wdogQ + 32'd1;
               end
`endif
            end
            ST_SETTLE: begin
               if (settleQ == SW'(SETTLE_CYCLES - 1)) begin
                  stateD = ST_DRAIN;
               end else begin
                  settleD = settleQ + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (outFire && (outCount == OUT_W'(N_OUT - 1))) begin
                  stateD = ST_DONE;
               end
            end
            ST_DONE: stateD = ST_IDLE;
            default: stateD = ST_IDLE;
         endcase
      end
   end

   // State registers with asynchronous active-high reset back to IDLE
   always_ff @(posedge axis_clk_i or posedge axis_rst_i) begin
      if (axis_rst_i) begin
         stateQ  <= ST_IDLE;
         typeQ   <= 1'b0;
         errQ    <= 1'b0;
         settleQ <= '0;
`ifdef SIFT_CTRL_TIMEOUT_EN
         wdogQ   <= '0;
`endif
      end else begin
         stateQ  <= stateD;
         typeQ   <= typeD;
         errQ    <= errD;
         settleQ <= settleD;
`ifdef SIFT_CTRL_TIMEOUT_EN
         wdogQ   <= wdogD;
`endif
      end
   end

endmodule

// File: tb/tb_axi_sift_sector_ctrl.sv
// Directed bench for axi_sift_sector_ctrl with a scoreboard on both streams.
// Build with SIFT_CTRL_TIMEOUT_EN to also exercise the RUN watchdog.
module tb_axi_sift_sector_ctrl;

   localparam int N_IN   = 342;
   localparam int N_OUT  = 252;
   localparam int SETTLE = 3;

   logic clock = 1'b0;
   logic reset, start, typeIn, abort, runEnd;
   logic busy, done, err, typeReg;

   logic        sTvalid, sTready, sTlast;
   logic [31:0] sTdata;
   logic        coreSTvalid, coreSTready, coreSTlast;
   logic [31:0] coreSTdata;
   logic        coreMTvalid, coreMTready;
   logic [31:0] coreMTdata;
   logic        mTvalid, mTready, mTlast;
   logic [31:0] mTdata;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb[$];

   // Free-running 100 MHz clock
   always #5 clock = ~clock;

`ifdef SIFT_CTRL_TIMEOUT_EN
   axi_sift_sector_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .axis_clk_i      (clock),
      .axis_rst_i      (reset),
      .start_i         (start),
      .type_i          (typeIn),
      .abort_i         (abort),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err),
      .type_reg_o      (typeReg),
      .s_axis_tvalid_i (sTvalid),
      .s_axis_tready_o (sTready),
      .s_axis_tdata_i  (sTdata),
      .s_axis_tlast_i  (sTlast),
      .core_s_tvalid_o (coreSTvalid),
      .core_s_tready_i (coreSTready),
      .core_s_tdata_o  (coreSTdata),
      .core_s_tlast_o  (coreSTlast),
      .run_end_i       (runEnd),
      .core_m_tvalid_i (coreMTvalid),
      .core_m_tready_o (coreMTready),
      .core_m_tdata_i  (coreMTdata),
      .m_axis_tvalid_o (mTvalid),
      .m_axis_tready_i (mTready),
      .m_axis_tdata_o  (mTdata),
      .m_axis_tlast_o  (mTlast)
   );
`else
   axi_sift_sector_ctrl dut (
      .axis_clk_i      (clock),
      .axis_rst_i      (reset),
      .start_i         (start),
      .type_i          (typeIn),
      .abort_i         (abort),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err),
      .type_reg_o      (typeReg),
      .s_axis_tvalid_i (sTvalid),
      .s_axis_tready_o (sTready),
      .s_axis_tdata_i  (sTdata),
      .s_axis_tlast_i  (sTlast),
      .core_s_tvalid_o (coreSTvalid),
      .core_s_tready_i (coreSTready),
      .core_s_tdata_o  (coreSTdata),
      .core_s_tlast_o  (coreSTlast),
      .run_end_i       (runEnd),
      .core_m_tvalid_i (coreMTvalid),
      .core_m_tready_o (coreMTready),
      .core_m_tdata_i  (coreMTdata),
      .m_axis_tvalid_o (mTvalid),
      .m_axis_tready_i (mTready),
      .m_axis_tdata_o  (mTdata),
      .m_axis_tlast_o  (mTlast)
   );
`endif

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expV);
      checks++;
      assert (obs === expV)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expV);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic startJob(input logic t);
      start  = 1'b1;
      typeIn = t;
      step();
      start = 1'b0;
      checkOutput("start_busy", busy, 1);
      checkOutput("start_type", typeReg, {31'b0, t});
   endtask

   // Loads n beats; host tlast is raised on the true final beat and on badBeat
   task automatic applyStimulus(input int n, input int badBeat);
      logic [31:0] d;
      logic [32:0] e;
      for (int i = 0; i < n; i++) begin
         d = $urandom();
         sTvalid     = 1'b1;
         sTdata      = d;
         sTlast      = (i == N_IN - 1) || (i == badBeat);
         coreSTready = 1'b1;
         sb.push_back({1'(i == N_IN - 1), d});
         #1;
         checkOutput("load_valid", coreSTvalid, 1);
         checkOutput("load_ready", sTready, 1);
         e = sb.pop_front();
         checkOutput("load_data", coreSTdata, e[31:0]);
         checkOutput("load_tlast", coreSTlast, {31'b0, e[32]});
         step();
         if (i == badBeat && i != N_IN - 1) checkOutput("err_set", err, 1);
      end
      sTvalid = 1'b0;
      sTlast  = 1'b0;
   endtask

   task automatic checkInRun();
      sTvalid     = 1'b1;
      coreSTready = 1'b1;
      #1;
      checkOutput("run_s_tready", sTready, 0);
      checkOutput("run_core_tvalid", coreSTvalid, 0);
      checkOutput("run_busy", busy, 1);
      sTvalid = 1'b0;
   endtask

   task automatic runAndSettle();
      int cnt;
      coreMTvalid = 1'b0;
      mTready     = 1'b1;
      runEnd      = 1'b1;
      step();
      runEnd = 1'b0;
      cnt = 0;
      while (!coreMTready && cnt < 20) begin
         step();
         cnt++;
      end
      checkOutput("settle_len", cnt, SETTLE);
   endtask

   task automatic drainBeats();
      int idx, cyc;
      logic [31:0] d;
      logic [32:0] e;
      idx = 0;
      cyc = 0;
      d = $urandom();
      sb.push_back({1'(N_OUT == 1), d});
      while (idx < N_OUT && cyc < 2000) begin
         coreMTvalid = 1'b1;
         coreMTdata  = d;
         mTready     = (cyc % 2 == 0);
         #1;
         checkOutput("drain_valid", mTvalid, 1);
         checkOutput("drain_data", mTdata, sb[0][31:0]);
         checkOutput("drain_core_ready", coreMTready, {31'b0, mTready});
         checkOutput("drain_done_low", done, 0);
         if (mTready) begin
            e = sb.pop_front();
            checkOutput("drain_tlast", mTlast, {31'b0, e[32]});
            idx++;
            if (idx < N_OUT) begin
               d = $urandom();
               sb.push_back({1'(idx == N_OUT - 1), d});
            end
         end
         step();
         cyc++;
      end
      coreMTvalid = 1'b0;
      mTready     = 1'b0;
      checkOutput("drain_beats", idx, N_OUT);
      checkOutput("done_pulse", done, 1);
      step();
      checkOutput("done_clear", done, 0);
      checkOutput("idle_busy", busy, 0);
   endtask

   // Global watchdog so a hung bench cannot run forever
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] time limit");
   end

   // Main directed sequence
   initial begin
      reset = 1'b1; start = 1'b0; typeIn = 1'b0; abort = 1'b0; runEnd = 1'b0;
      sTvalid = 1'b0; sTdata = '0; sTlast = 1'b0;
      coreSTready = 1'b0;
      coreMTvalid = 1'b0; coreMTdata = '0;
      mTready = 1'b0;
      #12;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_type", typeReg, 0);
      checkOutput("rst_s_tready", sTready, 0);
      checkOutput("rst_m_tvalid", mTvalid, 0);
      @(negedge clock) reset = 1'b0;
      step();

      runEnd = 1'b1;
      step();
      runEnd = 1'b0;
      checkOutput("idle_run_end", busy, 0);

      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      checkOutput("abort_wins", busy, 0);

      // Job 1: clean load, RUN hold, settle, toggling drain
      startJob(1'b1);
      coreSTready = 1'b0;
      sTvalid = 1'b1;
      #1;
      checkOutput("pass_valid", coreSTvalid, 1);
      checkOutput("pass_ready_low", sTready, 0);
      applyStimulus(N_IN, -1);
      checkOutput("job1_err", err, 0);
      checkInRun();
      repeat (50) step();
      checkOutput("run_hold", busy, 1);
      runAndSettle();
      drainBeats();

      // Job 2: early host tlast flags an error but load still runs 342 beats
      startJob(1'b0);
      applyStimulus(N_IN, 100);
      checkInRun();
      checkOutput("err_sticky", err, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checkOutput("abort_run_busy", busy, 0);
      checkOutput("abort_keeps_err", err, 1);
      checkOutput("abort_no_done", done, 0);

      // Job 3: abort mid-load, then a full fresh load and reset during drain
      startJob(1'b1);
      checkOutput("start_clears_err", err, 0);
      applyStimulus(50, -1);
      sTvalid = 1'b1;
      abort = 1'b1;
      step();
      abort = 1'b0;
      sTvalid = 1'b0;
      checkOutput("abort_load_busy", busy, 0);
      checkOutput("abort_load_ready", sTready, 0);
      startJob(1'b0);
      applyStimulus(N_IN, -1);
      checkInRun();
      runAndSettle();
      coreMTvalid = 1'b1;
      coreMTdata  = 32'hA5A5_0001;
      #1;
      checkOutput("drain_live", mTvalid, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_m_tvalid", mTvalid, 0);
      checkOutput("mid_rst_core_m_ready", coreMTready, 0);
      checkOutput("mid_rst_s_tready", sTready, 0);
      checkOutput("mid_rst_core_s_valid", coreSTvalid, 0);
      checkOutput("mid_rst_m_tlast", mTlast, 0);
      coreMTvalid = 1'b0;
      mTready     = 1'b0;
      sb.delete();
      @(negedge clock) reset = 1'b0;
      step();

`ifdef SIFT_CTRL_TIMEOUT_EN
      begin
         int cnt;
         startJob(1'b1);
         applyStimulus(N_IN, -1);
         cnt = 0;
         while (busy && cnt < 300) begin
            step();
            cnt++;
         end
         checkOutput("wdog_cycles", cnt, 100);
         checkOutput("wdog_err", err, 1);
      end
`endif

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
